// File: rtl/fp_alu_sequencer.sv
// Byte-serial sequencer between an 8-bit pin interface and a 32-bit FP ALU core.
// It collects two operands LSB first, launches the core, waits with a timeout, and streams the result out.
module fp_alu_sequencer #(
    parameter int DATA_W       = 32,
    parameter int BYTE_W       = 8,
    parameter int EXEC_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              start,
    input  logic [1:0]        opcode,
    output logic [BYTE_W-1:0] out_byte,
    output logic              done,
    output logic              err,
    output logic [3:0]        state_out,
    output logic [DATA_W-1:0] core_a,
    output logic [DATA_W-1:0] core_b,
    output logic [1:0]        core_op,
    output logic              core_start,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result
);
    localparam int NBYTES = DATA_W / BYTE_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W  = $clog2(EXEC_TIMEOUT + 1);
    localparam logic [DATA_W-1:0] QNAN = DATA_W'(32'h7FC0_0000);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD_A = 4'd1,
        S_LOAD_B = 4'd2,
        S_EXEC   = 4'd3,
        S_WAIT   = 4'd4,
        S_OUT    = 4'd5
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   byte_idx_reg;
    logic [CNT_W-1:0]   wait_cnt_reg;
    logic [DATA_W-1:0]  core_a_reg, core_b_reg, result_reg;
    logic [1:0]         core_op_reg;
    logic               err_reg;
    logic               last_byte, timeout;
    logic [BYTE_W-1:0]  res_bytes [NBYTES];

    assign last_byte = (byte_idx_reg == IDX_W'(NBYTES - 1));
    assign timeout   = ((wait_cnt_reg + 1'b1) == CNT_W'(EXEC_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start)                state_next = S_LOAD_A;
            S_LOAD_A: if (last_byte)            state_next = S_LOAD_B;
            S_LOAD_B: if (last_byte)            state_next = S_EXEC;
            S_EXEC:                             state_next = S_WAIT;
            S_WAIT:   if (core_done || timeout) state_next = S_OUT;
            S_OUT:    if (last_byte)            state_next = S_IDLE;
            default:                            state_next = S_IDLE;
        endcase
    end

    // Byte index is shared by both load phases and the output phase; it restarts at 0 on every phase change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_reg <= '0;
            wait_cnt_reg <= '0;
            core_op_reg  <= '0;
            result_reg   <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (state_reg == S_LOAD_A || state_reg == S_LOAD_B || state_reg == S_OUT)
                byte_idx_reg <= last_byte ? '0 : byte_idx_reg + 1'b1;
            else
                byte_idx_reg <= '0;

            wait_cnt_reg <= (state_reg == S_WAIT) ? wait_cnt_reg + 1'b1 : '0;

            if (state_reg == S_IDLE && start)
                core_op_reg <= opcode;

            if (state_reg == S_WAIT) begin
                if (core_done) begin
                    result_reg <= core_result;
                    err_reg    <= 1'b0;
                end else if (timeout) begin
                    result_reg <= QNAN;
                    err_reg    <= 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    core_a_reg[gi*BYTE_W +: BYTE_W] <= '0;
                    core_b_reg[gi*BYTE_W +: BYTE_W] <= '0;
                end else begin
                    if (state_reg == S_LOAD_A && byte_idx_reg == IDX_W'(gi))
                        core_a_reg[gi*BYTE_W +: BYTE_W] <= in_byte;
                    if (state_reg == S_LOAD_B && byte_idx_reg == IDX_W'(gi))
                        core_b_reg[gi*BYTE_W +: BYTE_W] <= in_byte;
                end
            end
            assign res_bytes[gi] = result_reg[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    always_comb begin
        core_start = (state_reg == S_EXEC);
        done       = (state_reg == S_OUT);
        err        = (state_reg == S_OUT) && err_reg;
        out_byte   = (state_reg == S_OUT) ? res_bytes[byte_idx_reg] : '0;
        state_out  = state_reg;
    end

    assign core_a  = core_a_reg;
    assign core_b  = core_b_reg;
    assign core_op = core_op_reg;
endmodule

// File: tb/tb_fp_alu_sequencer.sv
// Directed bench for fp_alu_sequencer: drives byte-serial transactions and plays a scripted core.
module tb_fp_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_byte = '0;
    logic        start = 1'b0;
    logic [1:0]  opcode = '0;
    logic [7:0]  out_byte;
    logic        done, err;
    logic [3:0]  state_out;
    logic [31:0] core_a, core_b;
    logic [1:0]  core_op;
    logic        core_start;
    logic        core_done = 1'b0;
    logic [31:0] core_result = '0;

    int total = 0;
    int bad = 0;

    fp_alu_sequencer #(.DATA_W(32), .BYTE_W(8), .EXEC_TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .start(start), .opcode(opcode),
        .out_byte(out_byte), .done(done), .err(err), .state_out(state_out),
        .core_a(core_a), .core_b(core_b), .core_op(core_op), .core_start(core_start),
        .core_done(core_done), .core_result(core_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction starting in IDLE. done_dly in 1..64 pulses core_done on that WAIT edge, else never.
    task automatic run_txn(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input int done_dly, input logic [31:0] res,
                           input bit hold, input bit glitch);
        logic [31:0] exp_res;
        logic        exp_err;
        int          exp_wait, waits;
        exp_res  = (done_dly >= 1 && done_dly <= 64) ? res : 32'h7FC0_0000;
        exp_err  = !(done_dly >= 1 && done_dly <= 64);
        exp_wait = exp_err ? 64 : done_dly;

        chk({name, " idle"}, 32'(state_out), 32'd0);
        start = 1'b1; opcode = op;
        tick();
        start = hold;
        chk({name, " load_a"}, 32'(state_out), 32'd1);
        for (int i = 0; i < 4; i++) begin
            in_byte = a[8*i +: 8];
            tick();
        end
        chk({name, " load_b"}, 32'(state_out), 32'd2);
        for (int i = 0; i < 4; i++) begin
            in_byte = b[8*i +: 8];
            if (glitch && i == 1) begin start = 1'b1; opcode = 2'd3; end
            if (glitch && i == 2) start = hold;
            tick();
        end
        in_byte = 8'hEE;
        chk({name, " exec"}, 32'(state_out), 32'd3);
        chk({name, " core_start"}, 32'(core_start), 32'd1);
        chk({name, " core_a"}, core_a, a);
        chk({name, " core_b"}, core_b, b);
        chk({name, " core_op"}, 32'(core_op), 32'(op));
        tick();
        chk({name, " wait"}, 32'(state_out), 32'd4);
        chk({name, " core_start_low"}, 32'(core_start), 32'd0);
        waits = 0;
        while (state_out == 4'd4 && waits < 200) begin
            waits++;
            core_done   = (waits == done_dly);
            core_result = res;
            tick();
            core_done = 1'b0;
        end
        chk({name, " wait_cycles"}, 32'(waits), 32'(exp_wait));
        for (int i = 0; i < 4; i++) begin
            chk({name, " out_state"}, 32'(state_out), 32'd5);
            chk({name, " out_byte"}, 32'(out_byte), 32'(exp_res[8*i +: 8]));
            chk({name, " done"}, 32'(done), 32'd1);
            chk({name, " err"}, 32'(err), 32'(exp_err));
            tick();
        end
        chk({name, " back_idle"}, 32'(state_out), 32'd0);
        chk({name, " done_low"}, 32'(done), 32'd0);
        chk({name, " err_low"}, 32'(err), 32'd0);
        chk({name, " out_low"}, 32'(out_byte), 32'd0);
        opcode = 2'd0;
        $display("txn %s a=%h b=%h op=%0d dly=%0d waits=%0d exp=%h err=%0b", name, a, b, op, done_dly, waits, exp_res, exp_err);
    endtask

    initial begin
        #2;
        chk("reset state", 32'(state_out), 32'd0);
        chk("reset core_a", core_a, 32'd0);
        chk("reset done", 32'(done), 32'd0);
        tick();
        #4 rst_n = 1'b1;
        tick();

        run_txn("t1", 32'h3FC0_0000, 32'h4010_0000, 2'd0, 3, 32'h4070_0000, 1'b0, 1'b0);
        run_txn("t2", 32'h1234_5678, 32'h9ABC_DEF0, 2'd1, 0, 32'h0, 1'b0, 1'b0);
        run_txn("t3", 32'hA1B2_C3D4, 32'h0102_0304, 2'd0, 5, 32'hCAFE_F00D, 1'b0, 1'b1);

        // Asynchronous reset in the middle of LOAD_B
        start = 1'b1; opcode = 2'd2;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_byte = 8'h55 + 8'(i);
            tick();
        end
        chk("t4 pre_reset", 32'(state_out), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t4 rst state", 32'(state_out), 32'd0);
        chk("t4 rst core_a", core_a, 32'd0);
        chk("t4 rst core_op", 32'(core_op), 32'd0);
        chk("t4 rst out", 32'(out_byte), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        $display("txn t4 reset mid LOAD_B state=%0d", state_out);
        run_txn("t4b", 32'h3FC0_0000, 32'h4010_0000, 2'd0, 3, 32'h4070_0000, 1'b0, 1'b0);

        // Spurious core_done in IDLE, then done on the timeout edge
        core_done = 1'b1; core_result = 32'hDEAD_BEEF;
        tick();
        core_done = 1'b0;
        chk("t5 spurious state", 32'(state_out), 32'd0);
        chk("t5 spurious out", 32'(out_byte), 32'd0);
        run_txn("t5", 32'h0000_0001, 32'h0000_0002, 2'd2, 64, 32'h4049_0FDB, 1'b0, 1'b0);

        run_txn("t6a", 32'h3F80_0000, 32'h4000_0000, 2'd1, 2, 32'h4040_0000, 1'b1, 1'b0);
        run_txn("t6b", 32'hC0A0_0000, 32'h4120_0000, 2'd3, 7, 32'hC248_0000, 1'b1, 1'b0);
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
